// File: rtl/maquina_coerencia_mesi.sv
// MESI state table for NUM_LINHAS lines of one cache: serves processor requests
// over a request/grant snooping bus and applies snooped messages to the same table.
//
// state    | meaning
// OCIOSO   | idle: evaluates processor requests and accepts snoops
// WB_CPU   | writing back an M line before a local miss goes to the bus
// PEDE     | bus requested; message issued and line updated in the grant cycle
// WB_SNOOP | writing back an M line hit by a snoop; then resumes the saved state
module maquina_coerencia_mesi #(
  parameter int NUM_LINHAS = 4,
  parameter int IDX_W      = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cpu_valid,
  input  logic [2:0]       cpu_op,
  input  logic [IDX_W-1:0] cpu_idx,
  output logic             cpu_ready,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [1:0]       bus_msg,
  output logic [IDX_W-1:0] bus_idx,
  input  logic             bus_compartilhado,
  input  logic             snoop_valid,
  input  logic [1:0]       snoop_msg,
  input  logic [IDX_W-1:0] snoop_idx,
  output logic             snoop_ready,
  output logic             snoop_compartilhado,
  output logic             writeBack,
  output logic [IDX_W-1:0] wb_idx,
  input  logic             wb_ready,
  input  logic [IDX_W-1:0] dbg_idx,
  output logic [1:0]       dbg_estado
);

  typedef enum logic [1:0] {OCIOSO, WB_CPU, PEDE, WB_SNOOP} fsm_t;

  localparam logic [1:0] ST_I = 2'b00, ST_M = 2'b01, ST_S = 2'b10, ST_E = 2'b11;
  localparam logic [1:0] MSG_INV = 2'b00, MSG_RM = 2'b01, MSG_WM = 2'b10, MSG_NONE = 2'b11;
  localparam logic [2:0] OP_RH = 3'b000, OP_RM = 3'b001, OP_WH = 3'b010, OP_WM = 3'b011;

  fsm_t             fsm, fsm_nxt, fsm_ret, ret_nxt;
  logic [1:0]       estado [NUM_LINHAS];
  logic [1:0]       estado_nxt [NUM_LINHAS];
  logic [IDX_W-1:0] req_idx, req_idx_nxt, snp_idx, snp_idx_nxt;
  logic             req_wr, req_wr_nxt, req_inv, req_inv_nxt;
  logic [1:0]       snp_new, snp_new_nxt;
  logic             cpu_ready_r, rdy_nxt, snoop_ready_r, snoop_ready_nxt;
  logic [1:0]       snp_cur, snp_tgt, cpu_cur, st_gnt;
  logic [2:0]       op_eff;
  logic             snp_acc, snp_wb;

  function automatic logic [1:0] snoop_alvo(input logic [1:0] st, input logic [1:0] msg);
    snoop_alvo = st;
    if (msg == MSG_RM) begin
      if (st == ST_M || st == ST_E) snoop_alvo = ST_S;
    end else if (msg != MSG_NONE) begin
      snoop_alvo = ST_I;
    end
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm           <= OCIOSO;
      fsm_ret       <= OCIOSO;
      for (int i = 0; i < NUM_LINHAS; i++) estado[i] <= ST_I;
      req_idx       <= '0;
      req_wr        <= 1'b0;
      req_inv       <= 1'b0;
      snp_idx       <= '0;
      snp_new       <= ST_I;
      cpu_ready_r   <= 1'b0;
      snoop_ready_r <= 1'b0;
    end else begin
      fsm           <= fsm_nxt;
      fsm_ret       <= ret_nxt;
      estado        <= estado_nxt;
      req_idx       <= req_idx_nxt;
      req_wr        <= req_wr_nxt;
      req_inv       <= req_inv_nxt;
      snp_idx       <= snp_idx_nxt;
      snp_new       <= snp_new_nxt;
      cpu_ready_r   <= rdy_nxt;
      snoop_ready_r <= snoop_ready_nxt;
    end
  end

  always_comb begin
    fsm_nxt     = fsm;
    ret_nxt     = fsm_ret;
    estado_nxt  = estado;
    req_idx_nxt = req_idx;
    req_wr_nxt  = req_wr;
    req_inv_nxt = req_inv;
    snp_idx_nxt = snp_idx;
    snp_new_nxt = snp_new;
    rdy_nxt     = 1'b0;
    bus_msg     = MSG_NONE;
    bus_idx     = '0;
    st_gnt      = estado[req_idx];

    // A snoop on the line being completed in this grant cycle is superseded by the local update.
    snp_cur = estado[snoop_idx];
    snp_tgt = snoop_alvo(snp_cur, snoop_msg);
    snp_acc = snoop_valid && snoop_ready_r && (snoop_msg != MSG_NONE) &&
              !(fsm == PEDE && bus_gnt && snoop_idx == req_idx);
    snp_wb  = snp_acc && (snp_cur == ST_M);
    if (snp_acc && !snp_wb) estado_nxt[snoop_idx] = snp_tgt;

    cpu_cur = estado[cpu_idx];
    op_eff  = cpu_op;
    if (cpu_cur == ST_I && cpu_op == OP_RH) op_eff = OP_RM;
    if (cpu_cur == ST_I && cpu_op == OP_WH) op_eff = OP_WM;

    case (fsm)
      OCIOSO: begin
        if (cpu_valid && !cpu_ready_r && !snp_wb) begin
          req_idx_nxt = cpu_idx;
          case (op_eff)
            OP_RH: rdy_nxt = 1'b1;
            OP_WH: begin
              if (cpu_cur == ST_S) begin
                req_wr_nxt  = 1'b1;
                req_inv_nxt = 1'b1;
                fsm_nxt     = PEDE;
              end else begin
                if (cpu_cur == ST_E) estado_nxt[cpu_idx] = ST_M;
                rdy_nxt = 1'b1;
              end
            end
            OP_RM, OP_WM: begin
              req_wr_nxt  = (op_eff == OP_WM);
              req_inv_nxt = 1'b0;
              fsm_nxt     = (cpu_cur == ST_M) ? WB_CPU : PEDE;
            end
            default: rdy_nxt = 1'b1;
          endcase
        end
      end
      WB_CPU: if (wb_ready) fsm_nxt = PEDE;
      PEDE: begin
        if (bus_gnt) begin
          bus_idx = req_idx;
          if (!req_wr) begin
            bus_msg                = MSG_RM;
            estado_nxt[req_idx]    = bus_compartilhado ? ST_S : ST_E;
          end else begin
            bus_msg                = (req_inv && st_gnt == ST_S) ? MSG_INV : MSG_WM;
            estado_nxt[req_idx]    = ST_M;
          end
          rdy_nxt = 1'b1;
          fsm_nxt = OCIOSO;
        end
      end
      WB_SNOOP: begin
        if (wb_ready) begin
          estado_nxt[snp_idx] = snp_new;
          fsm_nxt             = fsm_ret;
        end
      end
      default: fsm_nxt = OCIOSO;
    endcase

    if (snp_wb) begin
      snp_idx_nxt = snoop_idx;
      snp_new_nxt = snp_tgt;
      ret_nxt     = fsm_nxt;
      fsm_nxt     = WB_SNOOP;
    end
    snoop_ready_nxt = (fsm_nxt == OCIOSO) || (fsm_nxt == PEDE);
  end

  assign cpu_ready           = cpu_ready_r;
  assign snoop_ready         = snoop_ready_r;
  assign bus_req             = (fsm == PEDE);
  assign writeBack           = (fsm == WB_CPU) || (fsm == WB_SNOOP);
  assign wb_idx              = (fsm == WB_SNOOP) ? snp_idx : req_idx;
  assign snoop_compartilhado = (estado[snoop_idx] != ST_I);
  assign dbg_estado          = estado[dbg_idx];

endmodule

// File: tb/tb_maquina_coerencia_mesi.sv
// Directed bench: table of processor transactions against a responding bus/memory,
// plus hand sequences for snoop writeback, snoop-vs-pending race and mid-transaction reset.
module tb_maquina_coerencia_mesi;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_valid = 1'b0;
  logic [2:0] cpu_op = 3'b000;
  logic [1:0] cpu_idx = 2'd0;
  logic       cpu_ready;
  logic       bus_req;
  logic       bus_gnt = 1'b0;
  logic [1:0] bus_msg;
  logic [1:0] bus_idx;
  logic       bus_compartilhado = 1'b0;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_msg = 2'b11;
  logic [1:0] snoop_idx = 2'd0;
  logic       snoop_ready;
  logic       snoop_compartilhado;
  logic       writeBack;
  logic [1:0] wb_idx;
  logic       wb_ready = 1'b0;
  logic [1:0] dbg_idx = 2'd0;
  logic [1:0] dbg_estado;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  maquina_coerencia_mesi #(.NUM_LINHAS(4), .IDX_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_op(cpu_op), .cpu_idx(cpu_idx), .cpu_ready(cpu_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_msg(bus_msg), .bus_idx(bus_idx),
    .bus_compartilhado(bus_compartilhado),
    .snoop_valid(snoop_valid), .snoop_msg(snoop_msg), .snoop_idx(snoop_idx),
    .snoop_ready(snoop_ready), .snoop_compartilhado(snoop_compartilhado),
    .writeBack(writeBack), .wb_idx(wb_idx), .wb_ready(wb_ready),
    .dbg_idx(dbg_idx), .dbg_estado(dbg_estado)
  );

  typedef struct {
    logic [2:0] op;
    logic [1:0] idx;
    int         gd;    // bus_req cycles without grant before the grant cycle
    logic       sh;
    int         wbd;   // writeBack cycles until wb_ready (inclusive)
    logic [1:0] msg;   // expected bus message, 11 when no bus traffic
    int         msgc;
    int         rq;
    int         wbc;
    logic [1:0] st;
  } vec_t;

  vec_t tab [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cpu(input vec_t v, input int n);
    int rq = 0, wbc = 0, msgc = 0, rdy = 0, it = 0;
    logic [1:0] msg = 2'b11, midx = 2'b00, widx = 2'b00;
    @(negedge clock);
    cpu_valid = 1'b1; cpu_op = v.op; cpu_idx = v.idx;
    while (rdy == 0 && it < 40) begin
      @(negedge clock);
      it++;
      bus_gnt = 1'b0; wb_ready = 1'b0;
      if (cpu_ready) begin
        rdy = 1;
        cpu_valid = 1'b0;
      end else begin
        if (writeBack) begin
          wbc++; widx = wb_idx;
          wb_ready = (wbc >= v.wbd);
        end
        if (bus_req) begin
          rq++;
          if (rq > v.gd) begin bus_gnt = 1'b1; bus_compartilhado = v.sh; end
        end
        #1;
        if (bus_msg != 2'b11) begin msgc++; msg = bus_msg; midx = bus_idx; end
      end
    end
    chk($sformatf("v%0d_done", n), rdy, 1);
    chk($sformatf("v%0d_msg", n), msg, v.msg);
    chk($sformatf("v%0d_msgc", n), msgc, v.msgc);
    chk($sformatf("v%0d_busreq", n), rq, v.rq);
    chk($sformatf("v%0d_wbc", n), wbc, v.wbc);
    if (msgc > 0) chk($sformatf("v%0d_busidx", n), midx, v.idx);
    if (wbc > 0) chk($sformatf("v%0d_wbidx", n), widx, v.idx);
    dbg_idx = v.idx;
    #1;
    chk($sformatf("v%0d_state", n), dbg_estado, v.st);
    @(negedge clock);
    chk($sformatf("v%0d_single_ready", n), cpu_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0] = '{3'b001, 2'd1, 2, 1'b0, 0, 2'b01, 1, 3, 0, 2'b11}; // readMiss -> E
    tab[1] = '{3'b010, 2'd1, 0, 1'b0, 0, 2'b11, 0, 0, 0, 2'b01}; // writeHit E -> M silent
    tab[2] = '{3'b011, 2'd1, 0, 1'b0, 3, 2'b10, 1, 1, 3, 2'b01}; // writeMiss on M: wb then bus
    tab[3] = '{3'b000, 2'd0, 1, 1'b1, 0, 2'b01, 1, 2, 0, 2'b10}; // readHit on I, shared -> S
    tab[4] = '{3'b000, 2'd0, 0, 1'b0, 0, 2'b11, 0, 0, 0, 2'b10}; // readHit on S
    tab[5] = '{3'b010, 2'd3, 0, 1'b0, 0, 2'b10, 1, 1, 0, 2'b01}; // writeHit on I -> writeMiss
    tab[6] = '{3'b001, 2'd2, 0, 1'b1, 0, 2'b01, 1, 1, 0, 2'b10}; // readMiss shared -> S
    tab[7] = '{3'b111, 2'd2, 0, 1'b0, 0, 2'b11, 0, 0, 0, 2'b10}; // no-op code
    tab[8] = '{3'b010, 2'd0, 0, 1'b0, 0, 2'b00, 1, 1, 0, 2'b01}; // writeHit S -> invalidar

    #2;
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_writeBack", writeBack, 0);
    chk("rst_snoop_ready", snoop_ready, 0);
    chk("rst_bus_msg", bus_msg, 2'b11);
    chk("rst_bus_idx", bus_idx, 0);
    chk("rst_wb_idx", wb_idx, 0);
    chk("rst_snoop_comp", snoop_compartilhado, 0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    chk("idle_snoop_ready", snoop_ready, 1);

    for (int i = 0; i < 9; i++) run_cpu(tab[i], i);

    // snoop readMiss on M line 1: writeback then S
    @(negedge clock);
    snoop_idx = 2'd1; dbg_idx = 2'd1;
    #1;
    chk("snp_comp_M", snoop_compartilhado, 1);
    chk("snp_ready_before", snoop_ready, 1);
    snoop_valid = 1'b1; snoop_msg = 2'b01;
    @(negedge clock);
    snoop_valid = 1'b0; snoop_msg = 2'b11;
    chk("snp_ready_drop", snoop_ready, 0);
    chk("snp_wb", writeBack, 1);
    chk("snp_wb_idx", wb_idx, 1);
    chk("snp_state_hold", dbg_estado, 2'b01);
    @(negedge clock);
    chk("snp_wb_hold", writeBack, 1);
    wb_ready = 1'b1;
    @(negedge clock);
    wb_ready = 1'b0;
    chk("snp_wb_fall", writeBack, 0);
    chk("snp_ready_back", snoop_ready, 1);
    chk("snp_state_S", dbg_estado, 2'b10);

    // writeHit on S line 2 pending; snoop writeMiss invalidates it before grant
    @(negedge clock);
    cpu_valid = 1'b1; cpu_op = 3'b010; cpu_idx = 2'd2; dbg_idx = 2'd2;
    @(negedge clock);
    chk("race_bus_req", bus_req, 1);
    chk("race_no_msg", bus_msg, 2'b11);
    snoop_valid = 1'b1; snoop_msg = 2'b10; snoop_idx = 2'd2;
    @(negedge clock);
    snoop_valid = 1'b0; snoop_msg = 2'b11;
    chk("race_state_I", dbg_estado, 2'b00);
    chk("race_req_held", bus_req, 1);
    bus_gnt = 1'b1;
    #1;
    chk("race_msg_wm", bus_msg, 2'b10);
    chk("race_msg_idx", bus_idx, 2);
    @(negedge clock);
    bus_gnt = 1'b0;
    chk("race_ready", cpu_ready, 1);
    chk("race_state_M", dbg_estado, 2'b01);
    cpu_valid = 1'b0;
    @(negedge clock);
    chk("race_ready_pulse", cpu_ready, 0);
    chk("race_msg_idle", bus_msg, 2'b11);

    // reset during WB_CPU (line 0 is M)
    cpu_valid = 1'b1; cpu_op = 3'b011; cpu_idx = 2'd0;
    @(negedge clock);
    chk("wbcpu_active", writeBack, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_writeBack", writeBack, 0);
    chk("mid_rst_bus_req", bus_req, 0);
    chk("mid_rst_cpu_ready", cpu_ready, 0);
    chk("mid_rst_snoop_ready", snoop_ready, 0);
    chk("mid_rst_bus_msg", bus_msg, 2'b11);
    chk("mid_rst_wb_idx", wb_idx, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_idx = 2'(i);
      #1;
      chk($sformatf("mid_rst_line%0d", i), dbg_estado, 2'b00);
    end
    cpu_valid = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", writeBack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
